// File: rtl/itype_commit_checker.sv
// itype_commit_checker
//   In-order scoreboard for the RV32I OP-IMM stream of the Sodor 5-stage core.
//   OP-IMM fetches are decoded and queued. At retire, the head entry's result
//   is recomputed from a shadow register file and compared with the core's
//   writeback. Any other opcode is counted as skipped.
//
//   Optional feature: define ITYPE_CHK_CAPTURE_EN to build the first-mismatch
//   capture registers (cap_*). When it is undefined, cap_* are tied to 0.
//
// Ports
//   clk, reset_n          : clock; async active-low reset
//   fetch_valid/instr     : instruction accepted by the core
//   ret_valid/rd/wen/data : retirement report from writeback
//   init_we/addr/data     : shadow regfile preload (x0 ignored)
//   q_count               : queue occupancy
//   ret/mism/skip_count   : saturating counters
//   err_overflow/underflow/mismatch : sticky error flags
//   cap_instr/expect/actual         : first-mismatch capture
module itype_commit_checker #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     fetch_valid,
  input  logic [31:0]              fetch_instr,
  input  logic                     ret_valid,
  input  logic [4:0]               ret_rd,
  input  logic                     ret_wen,
  input  logic [31:0]              ret_data,
  input  logic                     init_we,
  input  logic [4:0]               init_addr,
  input  logic [31:0]              init_data,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic [CNT_W-1:0]         ret_count,
  output logic [CNT_W-1:0]         mism_count,
  output logic [CNT_W-1:0]         skip_count,
  output logic                     err_overflow,
  output logic                     err_underflow,
  output logic                     err_mismatch,
  output logic [31:0]              cap_instr,
  output logic [31:0]              cap_expect,
  output logic [31:0]              cap_actual
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [31:0] imm;
  } entry_t;

  entry_t      q_mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  // Entry 0 is never written; x0 reads are forced to 0 below.
  logic [31:0] shadow [32];

  entry_t      new_e, head;
  logic        is_opimm, empty, full, pop, push_req, push, ovf, udf, mism;
  logic [31:0] src, expected;
  logic [4:0]  shamt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Fetch-side decode
  always_comb begin
    is_opimm      = (fetch_instr[6:0] == 7'b0010011);
    new_e.instr   = fetch_instr;
    new_e.rd      = fetch_instr[11:7];
    new_e.funct3  = fetch_instr[14:12];
    new_e.rs1     = fetch_instr[19:15];
    new_e.imm     = {{20{fetch_instr[31]}}, fetch_instr[31:20]};
  end

  // Queue control. Full/empty come from pointers carrying a wrap bit.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop      = ret_valid && !empty;
  assign udf      = ret_valid && empty;
  assign push_req = fetch_valid && is_opimm;
  // A same-cycle pop frees the slot, so a push at full is accepted.
  assign push     = push_req && (!full || pop);
  assign ovf      = push_req && full && !pop;
  assign q_count  = wr_ptr - rd_ptr;

  // Retire-side expected result, read from the head and the pre-update shadow
  assign head  = q_mem[rd_ptr[AW-1:0]];
  assign src   = (head.rs1 == 5'd0) ? 32'd0 : shadow[head.rs1];
  assign shamt = head.imm[4:0];

  always_comb begin
    expected = 32'd0;
    unique case (head.funct3)
      3'd0: expected = src + head.imm;
      3'd1: expected = src << shamt;
      3'd2: expected = {31'd0, $signed(src) < $signed(head.imm)};
      3'd3: expected = {31'd0, src < head.imm};
      3'd4: expected = src ^ head.imm;
      3'd5: expected = head.imm[10] ? $unsigned($signed(src) >>> shamt) : (src >> shamt);
      3'd6: expected = src | head.imm;
      3'd7: expected = src & head.imm;
    endcase
  end

  // rd=0 entries only check the destination index; their data is ignored.
  assign mism = pop && ((ret_rd != head.rd) ||
                        ((head.rd != 5'd0) && (!ret_wen || (ret_data != expected))));

  // Storage with no reset: queue slots and shadow regfile
  always_ff @(posedge clk) begin
    if (push)
      q_mem[wr_ptr[AW-1:0]] <= new_e;
    if (init_we && (init_addr != 5'd0))
      shadow[init_addr] <= init_data;
    // Written after the preload so the retire write wins on an address clash.
    // Updated even on mismatch so one bad writeback does not cascade.
    if (pop && (head.rd != 5'd0))
      shadow[head.rd] <= expected;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      ret_count     <= '0;
      mism_count    <= '0;
      skip_count    <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      err_mismatch  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        ret_count <= sat_inc(ret_count);
      end
      if (mism) begin
        mism_count   <= sat_inc(mism_count);
        err_mismatch <= 1'b1;
      end
      if (fetch_valid && !is_opimm) skip_count <= sat_inc(skip_count);
      if (ovf) err_overflow  <= 1'b1;
      if (udf) err_underflow <= 1'b1;
    end
  end

`ifdef ITYPE_CHK_CAPTURE_EN
  logic captured;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      captured   <= 1'b0;
      cap_instr  <= '0;
      cap_expect <= '0;
      cap_actual <= '0;
    end else if (mism && !captured) begin
      captured   <= 1'b1;
      cap_instr  <= head.instr;
      cap_expect <= expected;
      cap_actual <= ret_data;
    end
  end
`else
  assign cap_instr  = '0;
  assign cap_expect = '0;
  assign cap_actual = '0;
`endif

endmodule

// File: tb/tb_itype_commit_checker.sv
module tb_itype_commit_checker;
  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  logic        clk, reset_n;
  logic        fetch_valid, ret_valid, ret_wen, init_we;
  logic [31:0] fetch_instr, ret_data, init_data;
  logic [4:0]  ret_rd, init_addr;
  logic [$clog2(DEPTH):0] q_count;
  logic [CNT_W-1:0] ret_count, mism_count, skip_count;
  logic        err_overflow, err_underflow, err_mismatch;
  logic [31:0] cap_instr, cap_expect, cap_actual;

  itype_commit_checker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
    .ret_valid(ret_valid), .ret_rd(ret_rd), .ret_wen(ret_wen), .ret_data(ret_data),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
    .q_count(q_count), .ret_count(ret_count), .mism_count(mism_count),
    .skip_count(skip_count), .err_overflow(err_overflow),
    .err_underflow(err_underflow), .err_mismatch(err_mismatch),
    .cap_instr(cap_instr), .cap_expect(cap_expect), .cap_actual(cap_actual)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_shadow [32];
  logic [31:0] m_q [$];
  int          m_ret, m_mism, m_skip;
  bit          m_ovf, m_udf, m_err, m_cap;
  logic [31:0] m_ci, m_ce, m_ca;

  function automatic int sat(input int v);
    return (v == (1 << CNT_W) - 1) ? v : v + 1;
  endfunction

  // Architectural OP-IMM result straight from the instruction word
  function automatic logic [31:0] op_result(input logic [31:0] ins, input logic [31:0] a);
    logic [31:0] imm;
    int sh;
    imm = {{20{ins[31]}}, ins[31:20]};
    sh  = int'(ins[24:20]);
    case (ins[14:12])
      3'd0: return a + imm;
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
      3'd3: return (a < imm) ? 32'd1 : 32'd0;
      3'd4: return a ^ imm;
      3'd5: return ins[30] ? 32'($signed(a) >>> sh) : (a >> sh);
      3'd6: return a | imm;
      default: return a & imm;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin : model
    bit          pop, mm;
    logic [31:0] e, a, x;
    logic [4:0]  rd;
    if (!reset_n) begin
      m_q.delete();
      m_ret = 0; m_mism = 0; m_skip = 0;
      m_ovf = 0; m_udf = 0; m_err = 0; m_cap = 0;
      m_ci = 0; m_ce = 0; m_ca = 0;
    end else begin
      pop = ret_valid && (m_q.size() > 0);
      rd  = 5'd0;
      x   = 32'd0;
      if (ret_valid && !pop) m_udf = 1;
      if (pop) begin
        e  = m_q.pop_front();
        rd = e[11:7];
        a  = (e[19:15] == 5'd0) ? 32'd0 : m_shadow[e[19:15]];
        x  = op_result(e, a);
        mm = (ret_rd != rd) || (rd != 0 && (!ret_wen || ret_data != x));
        m_ret = sat(m_ret);
        if (mm) begin
          m_mism = sat(m_mism);
          m_err  = 1;
          if (!m_cap) begin
            m_cap = 1; m_ci = e; m_ce = x; m_ca = ret_data;
          end
        end
      end
      if (init_we && init_addr != 0) m_shadow[init_addr] = init_data;
      if (pop && rd != 0) m_shadow[rd] = x;
      if (fetch_valid) begin
        if (fetch_instr[6:0] == 7'h13) begin
          if (m_q.size() == DEPTH) m_ovf = 1;
          else m_q.push_back(fetch_instr);
        end else m_skip = sat(m_skip);
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("q_count", 32'(q_count), m_q.size());
    chk("ret_count", 32'(ret_count), m_ret);
    chk("mism_count", 32'(mism_count), m_mism);
    chk("skip_count", 32'(skip_count), m_skip);
    chk("err_overflow", 32'(err_overflow), 32'(m_ovf));
    chk("err_underflow", 32'(err_underflow), 32'(m_udf));
    chk("err_mismatch", 32'(err_mismatch), 32'(m_err));
`ifdef ITYPE_CHK_CAPTURE_EN
    chk("cap_instr", cap_instr, m_ci);
    chk("cap_expect", cap_expect, m_ce);
    chk("cap_actual", cap_actual, m_ca);
`else
    chk("cap_instr", cap_instr, 32'd0);
    chk("cap_expect", cap_expect, 32'd0);
    chk("cap_actual", cap_actual, 32'd0);
`endif
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] enc(input logic [11:0] imm, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'h13};
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
    fetch_valid = 0; ret_valid = 0; init_we = 0;
  endtask

  task automatic fetch(input logic [31:0] i);
    fetch_valid = 1; fetch_instr = i; step();
  endtask

  task automatic retire(input logic [4:0] rd, input logic wen, input logic [31:0] d);
    ret_valid = 1; ret_rd = rd; ret_wen = wen; ret_data = d; step();
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    init_we = 1; init_addr = a; init_data = d; step();
  endtask

  // Directed single-op vectors, executed with x5=0x10, x2=0x80000000
  typedef struct { logic [31:0] ins; logic [4:0] rd; logic [31:0] res; } vec_t;
  vec_t vecs [10];

  initial begin
    reset_n = 0; fetch_valid = 0; ret_valid = 0; init_we = 0;
    fetch_instr = 0; ret_rd = 0; ret_wen = 0; ret_data = 0; init_addr = 0; init_data = 0;

    vecs[0] = '{enc(12'hFFF, 5, 2, 8),  8,  32'h0};         // slti  x8,x5,-1
    vecs[1] = '{enc(12'hFFF, 5, 3, 8),  8,  32'h1};         // sltiu x8,x5,-1
    vecs[2] = '{enc(12'h0FF, 5, 4, 9),  9,  32'h000000EF};  // xori
    vecs[3] = '{enc(12'hFF0, 5, 6, 9),  9,  32'hFFFFFFF0};  // ori  -16
    vecs[4] = '{enc(12'h018, 5, 7, 9),  9,  32'h00000010};  // andi
    vecs[5] = '{enc(12'h004, 5, 1, 10), 10, 32'h00000100};  // slli 4
    vecs[6] = '{enc(12'h004, 2, 5, 10), 10, 32'h08000000};  // srli 4
    vecs[7] = '{enc(12'hFE0, 5, 0, 11), 11, 32'hFFFFFFF0};  // addi -32
    vecs[8] = '{enc(12'h000, 2, 2, 12), 12, 32'h1};         // slti x12,x2,0
    vecs[9] = '{enc(12'h001, 5, 0, 0),  0,  32'hDEADBEEF};  // addi x0: data ignored

    step(); step();
    chk("rst_q_count", 32'(q_count), 0);
    chk("rst_err", {29'd0, err_overflow, err_underflow, err_mismatch}, 0);
    reset_n = 1;

    for (int r = 1; r < 32; r++) preload(5'(r), 32'd0);
    preload(5, 32'h00000010);
    preload(2, 32'h80000000);

    // ADDI
    fetch(32'h7FF28393);
    retire(7, 1, 32'h0000080F);
    chk("addi_ret_count", 32'(ret_count), 1);
    chk("addi_mism", 32'(mism_count), 0);
    chk("addi_q", 32'(q_count), 0);

    // SRAI good, then bad
    fetch(32'h40415093);
    retire(1, 1, 32'hF8000000);
    chk("srai_ok", 32'(err_mismatch), 0);
    fetch(32'h40415093);
    retire(1, 1, 32'h08000000);
    chk("srai_bad", 32'(err_mismatch), 1);
`ifdef ITYPE_CHK_CAPTURE_EN
    chk("cap_expect_lit", cap_expect, 32'hF8000000);
    chk("cap_actual_lit", cap_actual, 32'h08000000);
`endif

    // Skip
    fetch(32'h00002083);
    chk("skip_lit", 32'(skip_count), 1);
    chk("skip_q", 32'(q_count), 0);

    // Directed ops
    foreach (vecs[i]) begin
      fetch(vecs[i].ins);
      retire(vecs[i].rd, vecs[i].rd != 0, vecs[i].res);
    end
    chk("vec_mism", 32'(mism_count), 1);

    // Back-to-back dependency, second fetch overlaps first retire
    fetch(32'h00100193);
    fetch_valid = 1; fetch_instr = 32'h00118193;
    ret_valid = 1; ret_rd = 3; ret_wen = 1; ret_data = 32'd1;
    step();
    retire(3, 1, 32'd2);
    chk("dep_mism", 32'(mism_count), 1);

    // Wrong rd, then missing write enable
    fetch(32'h7FF28393);
    retire(6, 1, 32'h0000080F);
    fetch(32'h7FF28393);
    retire(7, 0, 32'h0000080F);
    chk("rd_wen_mism", 32'(mism_count), 3);
`ifdef ITYPE_CHK_CAPTURE_EN
    chk("cap_hold", cap_instr, 32'h40415093);
`endif

    // Queue limits
    reset_n = 0; step(); reset_n = 1;
    for (int i = 0; i < DEPTH; i++) fetch(32'h00000013);
    chk("full_q", 32'(q_count), DEPTH);
    chk("full_no_ovf", 32'(err_overflow), 0);
    fetch(32'h00000013);
    chk("ovf", 32'(err_overflow), 1);
    chk("ovf_q", 32'(q_count), DEPTH);
    fetch_valid = 1; fetch_instr = 32'h00000013;
    ret_valid = 1; ret_rd = 0; ret_wen = 0; ret_data = 0;
    step();
    chk("pushpop_full_q", 32'(q_count), DEPTH);
    for (int i = 0; i < DEPTH; i++) retire(0, 0, 0);
    chk("drain_q", 32'(q_count), 0);
    chk("drain_no_udf", 32'(err_underflow), 0);
    retire(0, 0, 0);
    chk("udf", 32'(err_underflow), 1);
    chk("udf_ret_count", 32'(ret_count), DEPTH + 1);

    // Reset mid-run
    reset_n = 0; step(); reset_n = 1;
    for (int i = 0; i < 3; i++) fetch(32'h00000013);
    chk("mid_q3", 32'(q_count), 3);
    reset_n = 0;
    #1;
    chk("mid_rst_q", 32'(q_count), 0);
    chk("mid_rst_ret", 32'(ret_count), 0);
    step();
    reset_n = 1;
    retire(0, 0, 0);
    chk("mid_udf", 32'(err_underflow), 1);
    chk("mid_ret", 32'(ret_count), 0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
